// File: rtl/half_vector_chunk_sender.sv
// Transmit side of the fixed-vector dot-product interface: buffers one A vector and a
// ping-pong pair of B vectors, then shifts A into the dot unit and streams B, MULTS elements per cycle.
module half_vector_chunk_sender #(
    parameter int unsigned BITS   = 16,
    parameter int unsigned LENGTH = 10,
    parameter int unsigned MULTS  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic                             wr_sel,
    input  logic [$clog2(LENGTH)-1:0]        wr_addr,
    input  logic [BITS-1:0]                  wr_data,
    input  logic                             start_load,
    input  logic                             start_stream,
    output logic                             busy,
    output logic                             done,
    output logic                             wr_err,
    output logic                             load_a,
    output logic [MULTS-1:0][BITS-1:0]       vector_a_in,
    output logic                             in_valid,
    output logic [MULTS-1:0][BITS-1:0]       vector_b
);

    localparam int unsigned CHUNKS = LENGTH / MULTS;
    localparam int unsigned AW     = $clog2(LENGTH);
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    if (LENGTH % MULTS != 0) begin : g_len_check
        $error("LENGTH must be a multiple of MULTS");
    end

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
    typedef logic [MULTS-1:0][BITS-1:0] chunk_t;

    logic [BITS-1:0] a_mem [LENGTH];
    logic [BITS-1:0] b_mem [2][LENGTH];

    state_t         state;
    logic [CW-1:0]  idx;
    logic           rd;
    logic           pending;
    logic           addr_ok;
    logic           a_blocked;
    logic           wr_accept;
    logic [CW-1:0]  a_sel;
    logic [CW-1:0]  b_sel;
    chunk_t         a_chunk;
    chunk_t         b_chunk;

    // Write qualification: out-of-range addresses and A writes during LOAD are dropped
    assign addr_ok   = {1'b0, wr_addr} < (AW + 1)'(LENGTH);
    assign a_blocked = !wr_sel && (state == LOAD);
    assign wr_accept = wr_en && addr_ok && !a_blocked;

    // Element RAM; B writes always go to the bank not being read
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (wr_sel) b_mem[~rd][wr_addr] <= wr_data;
            else        a_mem[wr_addr]      <= wr_data;
        end
    end

    // Chunk to be registered onto the outputs at the coming edge
    always_comb begin
        a_sel = (state == LOAD)   ? idx - CW'(1) : LAST;
        b_sel = (state == STREAM) ? idx + CW'(1) : '0;
        for (int j = 0; j < int'(MULTS); j++) begin
            a_chunk[j] = a_mem[AW'(int'(a_sel) * int'(MULTS) + j)];
            b_chunk[j] = b_mem[rd][AW'(int'(b_sel) * int'(MULTS) + j)];
        end
    end

    // Sequencer: A goes out last chunk first so the receiver's upward shift lands A[k] in slot k
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            rd          <= 1'b0;
            pending     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            load_a      <= 1'b0;
            in_valid    <= 1'b0;
            vector_a_in <= '0;
            vector_b    <= '0;
        end else begin
            done     <= 1'b0;
            load_a   <= 1'b0;
            in_valid <= 1'b0;
            wr_err   <= wr_en && !wr_accept;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        idx         <= LAST;
                        pending     <= start_stream;
                        load_a      <= 1'b1;
                        vector_a_in <= a_chunk;
                    end else if (start_stream) begin
                        state    <= STREAM;
                        busy     <= 1'b1;
                        idx      <= '0;
                        in_valid <= 1'b1;
                        vector_b <= b_chunk;
                    end
                end
                LOAD: begin
                    if (idx == '0) begin
                        if (pending) begin
                            state    <= STREAM;
                            pending  <= 1'b0;
                            idx      <= '0;
                            in_valid <= 1'b1;
                            vector_b <= b_chunk;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        idx         <= a_sel;
                        load_a      <= 1'b1;
                        vector_a_in <= a_chunk;
                    end
                end
                STREAM: begin
                    if (idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rd    <= ~rd;
                    end else begin
                        idx      <= b_sel;
                        in_valid <= 1'b1;
                        vector_b <= b_chunk;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
